// File: rtl/pbs_pkg.sv
// pbs_pkg: shared constants and types for the PBS battle HP datapath.
package pbs_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_APPLY, S_DONE} state_t;
  localparam logic [1:0] EFF_X1 = 2'b00;
  localparam logic [1:0] EFF_X2 = 2'b01;
  localparam logic [1:0] EFF_HALF = 2'b10;
  localparam logic [1:0] EFF_X0 = 2'b11;
  localparam logic [3:0][7:0] MOVE_POWER = {8'd40, 8'd30, 8'd20, 8'd10};
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // taps 8,6,5,4 expressed as zero-based bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
endpackage

// File: rtl/pbs_lfsr8.sv
// pbs_lfsr8: free-running 8-bit Fibonacci LFSR used for critical-hit rolls.
module pbs_lfsr8
  import pbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] q
);
  logic [7:0] q_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q_q <= LFSR_SEED;
    else q_q <= {q_q[6:0], ^(q_q & LFSR_TAPS)};
  assign q = q_q;
endmodule

// File: rtl/pbs_hp_unit.sv
// pbs_hp_unit: battle HP datapath, 4-cycle damage pipeline with saturating HP writes.
// Define PBS_CRIT_EN to build the LFSR-driven critical-hit feature.
module pbs_hp_unit
  import pbs_pkg::*;
#(
  parameter int HP_W = 8,
  parameter int P_MAX_HP = 100,
  parameter int AI_MAX_HP = 100
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_ai_hp,
  input  logic            apply_ai_damage,
  input  logic            apply_p_damage,
  input  logic            active_trainer,
  input  logic            target,
  input  logic [1:0]      p_move,
  input  logic [1:0]      ai_move,
  input  logic [1:0]      eff,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_dead,
  output logic            ai_dead,
  output logic            busy,
  output logic            done,
  output logic            crit
);
  localparam int DW = HP_W + 2;
  state_t state_q;
  logic tgt_ai_q, crit_q, hit_crit, unused_bits;
  logic [1:0] move_q, eff_q;
  logic [HP_W-1:0] p_hp_q, p_hp_d, ai_hp_q, ai_hp_d, dmg;
  logic [DW-1:0] base, scaled;
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] d);
    return hp > d ? hp - d : '0;
  endfunction
`ifdef PBS_CRIT_EN
  logic [7:0] lfsr;
  pbs_lfsr8 u_lfsr (.clk(clk), .reset_n(reset_n), .q(lfsr));
  assign hit_crit = lfsr[2:0] == 3'd0;
  assign crit = state_q == S_DONE && crit_q;
  assign unused_bits = ^{target, lfsr[7:3]};
`else
  assign hit_crit = 1'b0;
  assign crit = 1'b0;
  assign unused_bits = target;
`endif
  always_comb begin
    base = DW'(MOVE_POWER[move_q]) << crit_q;
    scaled = eff_q == EFF_X2 ? base << 1 : eff_q == EFF_HALF ? base >> 1 : eff_q == EFF_X0 ? '0 : base;
    dmg = scaled > DW'({HP_W{1'b1}}) ? '1 : scaled[HP_W-1:0];
    p_hp_d = state_q == S_APPLY && !tgt_ai_q ? sat_sub(p_hp_q, dmg) : p_hp_q;
    ai_hp_d = load_ai_hp ? HP_W'(AI_MAX_HP) : state_q == S_APPLY && tgt_ai_q ? sat_sub(ai_hp_q, dmg) : ai_hp_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      tgt_ai_q <= 1'b0;
      crit_q <= 1'b0;
      move_q <= '0;
      eff_q <= EFF_X1;
      p_hp_q <= HP_W'(P_MAX_HP);
      ai_hp_q <= HP_W'(AI_MAX_HP);
    end else begin
      p_hp_q <= p_hp_d;
      ai_hp_q <= ai_hp_d;
      case (state_q)
        S_IDLE: if (apply_ai_damage || apply_p_damage) begin
          state_q <= S_CALC;
          tgt_ai_q <= apply_ai_damage;
        end
        S_CALC: begin
          state_q <= S_APPLY;
          move_q <= active_trainer ? ai_move : p_move;
          eff_q <= eff;
          crit_q <= hit_crit;
        end
        S_APPLY: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  assign p_hp = p_hp_q;
  assign ai_hp = ai_hp_q;
  assign p_dead = p_hp_q == '0;
  assign ai_dead = ai_hp_q == '0;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_pbs_hp_unit.sv
// tb_pbs_hp_unit: vector table, corner sequences and randomized hits against an arithmetic HP model.
module tb_pbs_hp_unit;
  logic clk = 0, reset_n = 0, load_ai_hp = 0, apply_ai_damage = 0, apply_p_damage = 0;
  logic active_trainer = 0, target = 0;
  logic [1:0] p_move = 0, ai_move = 0, eff = 0;
  logic [7:0] p_hp, ai_hp;
  logic p_dead, ai_dead, busy, done, crit;
  int checks = 0, failures = 0;
  int m_p = 100, m_ai = 100;
  logic [7:0] m_lfsr;
`ifdef PBS_CRIT_EN
  localparam bit CRIT_EN = 1;
`else
  localparam bit CRIT_EN = 0;
`endif

  pbs_hp_unit dut (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp), .apply_ai_damage(apply_ai_damage),
    .apply_p_damage(apply_p_damage), .active_trainer(active_trainer), .target(target),
    .p_move(p_move), .ai_move(ai_move), .eff(eff), .p_hp(p_hp), .ai_hp(ai_hp),
    .p_dead(p_dead), .ai_dead(ai_dead), .busy(busy), .done(done), .crit(crit)
  );

  always #5 clk = ~clk;

  // reference LFSR: x^8+x^6+x^5+x^4, new bit shifted in at the bottom
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int hp_after(input int hp, input int d);
    return hp > d ? hp - d : 0;
  endfunction

  function automatic int damage(input int mv, input int e, input bit cr);
    int pw = 10 * (mv + 1) * (cr ? 2 : 1);
    int d = e == 1 ? pw * 2 : e == 2 ? pw / 2 : e == 3 ? 0 : pw;
    return d > 255 ? 255 : d;
  endfunction

  task automatic do_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    m_p = 100;
    m_ai = 100;
  endtask

  task automatic idle_load();
    @(negedge clk);
    load_ai_hp = 1;
    @(negedge clk);
    load_ai_hp = 0;
    m_ai = 100;
    chk("idle_load", ai_hp, 100);
  endtask

  task automatic hit(input bit ai, input bit p, input bit tr, input logic [1:0] pm, input logic [1:0] am,
                     input logic [1:0] e, input bit ld_apply);
    bit cr;
    int d;
    @(negedge clk);
    apply_ai_damage = ai; apply_p_damage = p; active_trainer = tr; target = ai;
    p_move = pm; ai_move = am; eff = e;
    @(negedge clk);
    apply_ai_damage = 0; apply_p_damage = 0;
    chk("busy_calc", busy, 1);
    chk("done_calc", done, 0);
    cr = CRIT_EN && m_lfsr[2:0] == 3'd0;
    @(negedge clk);
    chk("busy_apply", busy, 1);
    chk("hp_hold_apply", ai ? ai_hp : p_hp, ai ? m_ai : m_p);
    load_ai_hp = ld_apply;
    d = damage(tr ? am : pm, e, cr);
    if (ai) m_ai = hp_after(m_ai, d);
    else m_p = hp_after(m_p, d);
    if (ld_apply) m_ai = 100;
    @(negedge clk);
    load_ai_hp = 0;
    chk("p_hp", p_hp, m_p);
    chk("ai_hp", ai_hp, m_ai);
    chk("p_dead", p_dead, m_p == 0);
    chk("ai_dead", ai_dead, m_ai == 0);
    chk("done", done, 1);
    chk("crit", crit, cr);
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  typedef struct {
    bit ai, p, tr;
    logic [1:0] pm, am, e;
    int exp_p, exp_ai;
  } vec_t;

  initial begin
    vec_t tbl[$];
    do_reset();
    chk("rst_p_hp", p_hp, 100);
    chk("rst_ai_hp", ai_hp, 100);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crit", crit, 0);
    chk("rst_dead", {p_dead, ai_dead}, 0);
`ifndef PBS_CRIT_EN
    tbl.push_back('{1, 0, 0, 2'd2, 2'd0, 2'b01, 100, 40});
    tbl.push_back('{1, 0, 0, 2'd2, 2'd0, 2'b01, 100, 0});
    tbl.push_back('{0, 1, 1, 2'd0, 2'd3, 2'b10, 80, 0});
    tbl.push_back('{0, 1, 1, 2'd0, 2'd3, 2'b11, 80, 0});
    tbl.push_back('{0, 1, 0, 2'd1, 2'd0, 2'b00, 60, 0});
    tbl.push_back('{1, 0, 1, 2'd0, 2'd0, 2'b01, 60, 0});
    tbl.push_back('{0, 1, 1, 2'd3, 2'd3, 2'b01, 0, 0});
    foreach (tbl[i]) begin
      hit(tbl[i].ai, tbl[i].p, tbl[i].tr, tbl[i].pm, tbl[i].am, tbl[i].e, 0);
      chk($sformatf("tbl%0d_p", i), p_hp, tbl[i].exp_p);
      chk($sformatf("tbl%0d_ai", i), ai_hp, tbl[i].exp_ai);
    end
    // simultaneous requests: AI wins; further requests while busy are dropped
    do_reset();
    @(negedge clk);
    apply_ai_damage = 1; apply_p_damage = 1; active_trainer = 0; p_move = 1; eff = 0;
    @(negedge clk);
    apply_ai_damage = 0;
    repeat (3) @(negedge clk);
    apply_p_damage = 0;
    repeat (4) @(negedge clk);
    chk("coll_ai", ai_hp, 80);
    chk("coll_p", p_hp, 100);
    chk("coll_busy", busy, 0);
    m_ai = 80;
    // load in APPLY overrides a lethal AI write
    hit(1, 0, 0, 2'd3, 2'd0, 2'b01, 1);
    chk("load_apply_ai", ai_hp, 100);
    chk("load_apply_dead", ai_dead, 0);
    // async reset in CALC
    hit(0, 1, 1, 2'd0, 2'd3, 2'b00, 0);
    chk("pre_rst_p", p_hp, 60);
    @(negedge clk);
    apply_ai_damage = 1;
    @(negedge clk);
    apply_ai_damage = 0;
    reset_n = 0;
    #1;
    chk("arst_p", p_hp, 100);
    chk("arst_ai", ai_hp, 100);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    reset_n = 1;
    m_p = 100;
    m_ai = 100;
`else
    for (int i = 0; i < 64; i++) begin
      int before;
      if (m_ai <= 20) idle_load();
      before = m_ai;
      hit(1, 0, 0, 2'd0, 2'd0, 2'b00, 0);
      chk("crit_dmg_range", (before - ai_hp == 10 || before - ai_hp == 20), 1);
      chk("crit_vs_dmg", crit, before - ai_hp == 20);
    end
`endif
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) idle_load();
      if (m_p == 0) do_reset();
      hit(r[0], r[1], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pbs_hp_unit.md
# pbs_hp_unit

Battle HP datapath for the PBS (Pokémon Battle Simulator) design. It sits directly downstream of the battle control FSM and consumes its `load_ai_hp`, `apply_ai_damage`, `apply_p_damage`, `active_trainer` and `target` strobes. For each damage request it computes move damage through a small multi-cycle pipeline and applies it to the player or AI HP register with saturation. It returns `ai_dead` and `p_hp` to the FSM.

## Interface
- `HP_W`, default 8: HP and damage width.
- `P_MAX_HP`, default 100: player HP after reset.
- `AI_MAX_HP`, default 100: AI HP after reset and after `load_ai_hp`.
- `clk  in  1`: single clock; all state updates on rising edge.
- `reset_n  in  1`: reset is asynchronous and active-low.
- `load_ai_hp  in  1`: reload AI HP to `AI_MAX_HP`.
- `apply_ai_damage  in  1`: damage request against AI; single-cycle pulse.
- `apply_p_damage  in  1`: damage request against player; single-cycle pulse.
- `active_trainer  in  1`: attacker select; 0 = player, 1 = AI.
- `target  in  1`: informational copy from the FSM; 1 = AI, 0 = player. Not used to select the register.
- `p_move  in  2`: player move index.
- `ai_move  in  2`: AI move index.
- `eff  in  2`: type effectiveness code; 00 = ×1, 01 = ×2, 10 = ×½ (floor), 11 = ×0.
- `p_hp  out  HP_W`: player HP register.
- `ai_hp  out  HP_W`: AI HP register.
- `p_dead  out  1`: `p_hp == 0`. Combinational from the register, no added latency.
- `ai_dead  out  1`: `ai_hp == 0`. Combinational from the register.
- `busy  out  1`: high while a request is in flight.
- `done  out  1`: one-cycle pulse after an HP write.
- `crit  out  1`: qualifies `done`; high when the applied hit was critical.

## Operation
- States:
  - IDLE: `busy` = 0.
  - CALC: latch attacker move, `eff` and target.
  - APPLY: compute damage and write HP.
  - DONE: `done` = 1.
- Transitions: IDLE→CALC on any request. CALC→APPLY, APPLY→DONE and DONE→IDLE are unconditional.
- Requests are sampled only in IDLE. Requests arriving in CALC, APPLY or DONE are dropped silently.
- If `apply_ai_damage` and `apply_p_damage` are asserted together, `apply_ai_damage` wins and the player request is dropped.
- Move power table (index 0..3): 10, 20, 30, 40.
  - Attacker move is `p_move` when `active_trainer` = 0, otherwise `ai_move`.
  - All moves are latched in CALC.
- Damage calculation:
  - Damage = power scaled by `eff`. ×2 is a left shift, ×½ is a right shift, ×0 gives 0.
  - Computed at width HP_W+2, then clamped to 2^HP_W−1.
- HP write: new HP = HP − damage when HP > damage, else 0. HP never wraps.
- `load_ai_hp` is honoured in any state:
  - It sets `ai_hp` = `AI_MAX_HP`.
  - It has priority over an APPLY write to AI in the same cycle; that write is discarded, but `done` still pulses.
- Damage to an HP register already at 0 leaves it at 0. `done` still pulses.

## Timing
- Reset values: `p_hp` = `P_MAX_HP`, `ai_hp` = `AI_MAX_HP`, state = IDLE, `busy`/`done`/`crit` = 0, `p_dead`/`ai_dead` = 0.
- Request sampled at edge E0 → CALC. Edge E1 → APPLY. HP register updates at edge E2 → DONE. Edge E3 → IDLE.
- Latency: HP and `*_dead` are valid 2 edges after the request edge. `done` is high in the cycle after E2.
- `busy` is high from E0 to E3. Throughput: one request per 4 cycles.
- Reset asserted mid-operation aborts the operation immediately; all registers return to their reset values.

## Configuration
- `PBS_CRIT_EN` defined:
  - An 8-bit Fibonacci LFSR is instantiated: taps 8,6,5,4; seed 8'hA5 on reset; advances every clock.
  - In CALC, `lfsr[2:0] == 0` marks the hit as critical. Damage is doubled before the `eff` scaling and clamp.
  - `crit` pulses together with `done`.
- `PBS_CRIT_EN` undefined: no LFSR is built and `crit` is tied to 0. Damage is power × `eff` only.

## Structure
- Shared package `pbs_pkg`:
  - move power table constant;
  - `eff` encoding localparams;
  - state enum for IDLE/CALC/APPLY/DONE;
  - LFSR seed and tap constants.
- Sub-module `pbs_lfsr8`, instantiated only under `PBS_CRIT_EN`. Ports: `clk`, `reset_n`, `q[7:0]`.

## Test plan
All scenarios use default parameters and `PBS_CRIT_EN` undefined unless stated.
- Reset, then player attacks AI with `p_move`=2 and `eff`=01 → `ai_hp` 100→40 at E2; `done` pulses one cycle later; `busy` is high for 4 cycles.
- Repeat the same hit → `ai_hp` = 0 (saturated, no wrap) and `ai_dead` = 1 at E2.
- AI attacks player with `ai_move`=3 and `eff`=10 → `p_hp` 100→80. With `eff`=11 → `p_hp` unchanged and `done` still pulses.
- `apply_ai_damage` and `apply_p_damage` in the same cycle, then a second request while `busy` → only the AI is damaged and the second request is ignored.
- `load_ai_hp` in the APPLY cycle of an AI hit → `ai_hp` = 100 and `ai_dead` = 0. Separately, `reset_n` low in CALC → `p_hp`/`ai_hp` = 100 and `busy` = 0 without waiting for a clock edge.
- With `PBS_CRIT_EN` defined, issue 64 hits of `p_move`=0, `eff`=00 (AI HP reloaded as needed) → each applied damage is 10 or 20, `crit` is high exactly on the 20-damage hits, and the sequence matches a reference LFSR model seeded 8'hA5.
